// File: rtl/pu_riscv_pma_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pu_riscv_pma_dispatch
// Brief    : Registered dispatch stage behind the PMA checker. Captures one
//            checked request, routes it to cache, BIU or TCM, holds the
//            target request until acknowledged and returns one registered
//            response. Faulting requests are answered locally.
// Revision : 1.0 - initial release
// ============================================================================
module pu_riscv_pma_dispatch #(
  parameter int XLEN    = 64,
  parameter int PLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  output logic            ready_o,
  input  logic [PLEN-1:0] adr_i,
  input  logic [2:0]      size_i,
  input  logic            we_i,
  input  logic            lock_i,
  input  logic [XLEN-1:0] d_i,
  input  logic            exception_i,
  input  logic            misaligned_i,
  input  logic            is_cache_access_i,
  input  logic            is_ext_access_i,
  input  logic            is_tcm_access_i,
  input  logic            flush_i,
  output logic            cache_req_o,
  input  logic            cache_ack_i,
  input  logic            cache_err_i,
  input  logic [XLEN-1:0] cache_q_i,
  output logic            ext_req_o,
  input  logic            ext_ack_i,
  input  logic            ext_err_i,
  input  logic [XLEN-1:0] ext_q_i,
  output logic            tcm_req_o,
  input  logic            tcm_ack_i,
  input  logic            tcm_err_i,
  input  logic [XLEN-1:0] tcm_q_i,
  output logic [PLEN-1:0] tgt_adr_o,
  output logic [2:0]      tgt_size_o,
  output logic            tgt_we_o,
  output logic            tgt_lock_o,
  output logic [XLEN-1:0] tgt_d_o,
  output logic            ack_o,
  output logic [XLEN-1:0] q_o,
  output logic            err_o,
  output logic            misaligned_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CACHE = 3'd1;
  localparam logic [2:0] ST_EXT   = 3'd2;
  localparam logic [2:0] ST_TCM   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Watchdog counter width; a disabled watchdog keeps a harmless 1-bit counter
  localparam int             WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [2:0]      state_q, state_d;
  logic [PLEN-1:0] adr_q, adr_d;
  logic [2:0]      size_q, size_d;
  logic            we_q, we_d;
  logic            lock_q, lock_d;
  logic [XLEN-1:0] dat_q, dat_d;
  logic            ack_q, ack_d;
  logic [XLEN-1:0] rq_q, rq_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            discard_q, discard_d;

  // Response signals of whichever target the current state selects
  logic            sel_ack, sel_err;
  logic [XLEN-1:0] sel_q;
  logic            wd_expired;

  assign sel_ack = (state_q == ST_CACHE && cache_ack_i) ||
                   (state_q == ST_EXT   && ext_ack_i)   ||
                   (state_q == ST_TCM   && tcm_ack_i);
  assign sel_err = (state_q == ST_CACHE && cache_err_i) ||
                   (state_q == ST_EXT   && ext_err_i)   ||
                   (state_q == ST_TCM   && tcm_err_i);
  assign sel_q   = (state_q == ST_CACHE) ? cache_q_i :
                   (state_q == ST_EXT)   ? ext_q_i   :
                   (state_q == ST_TCM)   ? tcm_q_i   : '0;
  assign wd_expired = (TIMEOUT != 0) && (state_q == ST_EXT) && (wd_q == WD_LAST);

  // State and datapath registers; async reset aborts any in-flight access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      lock_q    <= 1'b0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      rq_q      <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      wd_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      size_q    <= size_d;
      we_q      <= we_d;
      lock_q    <= lock_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      rq_q      <= rq_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
      wd_q      <= wd_d;
      discard_q <= discard_d;
    end
  end

  // Next-state: routing on acceptance, completion on ack or watchdog expiry
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    size_d    = size_q;
    we_d      = we_q;
    lock_d    = lock_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    rq_d      = rq_q;
    err_d     = err_q;
    mis_d     = mis_q;
    wd_d      = wd_q;
    discard_d = discard_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          adr_d     = adr_i;
          size_d    = size_i;
          we_d      = we_i;
          lock_d    = lock_i;
          dat_d     = d_i;
          wd_d      = '0;
          discard_d = 1'b0;
          if (exception_i || misaligned_i) begin
            // Fault answered next cycle while sitting in FAULT
            state_d = ST_FAULT;
            ack_d   = 1'b1;
            rq_d    = '0;
            err_d   = exception_i;
            mis_d   = misaligned_i;
          end else if (is_tcm_access_i) begin
            state_d = ST_TCM;
          end else if (is_cache_access_i) begin
            state_d = ST_CACHE;
          end else if (is_ext_access_i) begin
            state_d = ST_EXT;
          end else begin
            // No target claims the address: report as access fault
            state_d = ST_FAULT;
            ack_d   = 1'b1;
            rq_d    = '0;
            err_d   = 1'b1;
            mis_d   = 1'b0;
          end
        end
      end
      ST_CACHE, ST_EXT, ST_TCM: begin
        if (flush_i) discard_d = 1'b1;
        if (sel_ack) begin
          state_d   = ST_IDLE;
          ack_d     = !(discard_q || flush_i);
          rq_d      = we_q ? '0 : sel_q;
          err_d     = sel_err;
          mis_d     = 1'b0;
          discard_d = 1'b0;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          ack_d     = !(discard_q || flush_i);
          rq_d      = '0;
          err_d     = 1'b1;
          mis_d     = 1'b0;
          discard_d = 1'b0;
        end else if (state_q == ST_EXT) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_FAULT: begin
        state_d   = ST_IDLE;
        discard_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: per-target requests and ready decoded from the state register
  always_comb begin
    ready_o     = (state_q == ST_IDLE);
    cache_req_o = (state_q == ST_CACHE);
    ext_req_o   = (state_q == ST_EXT);
    tcm_req_o   = (state_q == ST_TCM);
  end

  assign tgt_adr_o    = adr_q;
  assign tgt_size_o   = size_q;
  assign tgt_we_o     = we_q;
  assign tgt_lock_o   = lock_q;
  assign tgt_d_o      = dat_q;
  assign ack_o        = ack_q;
  assign q_o          = rq_q;
  assign err_o        = err_q;
  assign misaligned_o = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_riscv_pma_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pu_riscv_pma_dispatch
// Brief    : Directed scoreboard bench for pu_riscv_pma_dispatch
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_riscv_pma_dispatch;

  localparam int XLEN = 64;
  localparam int PLEN = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_i, ready_o;
  logic [PLEN-1:0] adr_i;
  logic [2:0]      size_i;
  logic            we_i, lock_i;
  logic [XLEN-1:0] d_i;
  logic            exception_i, misaligned_i;
  logic            is_cache_access_i, is_ext_access_i, is_tcm_access_i;
  logic            flush_i;
  logic            cache_req_o, cache_ack_i, cache_err_i;
  logic [XLEN-1:0] cache_q_i;
  logic            ext_req_o, ext_ack_i, ext_err_i;
  logic [XLEN-1:0] ext_q_i;
  logic            tcm_req_o, tcm_ack_i, tcm_err_i;
  logic [XLEN-1:0] tcm_q_i;
  logic [PLEN-1:0] tgt_adr_o;
  logic [2:0]      tgt_size_o;
  logic            tgt_we_o, tgt_lock_o;
  logic [XLEN-1:0] tgt_d_o;
  logic            ack_o;
  logic [XLEN-1:0] q_o;
  logic            err_o, misaligned_o;

  always #5 clk_i = ~clk_i;

  pu_riscv_pma_dispatch #(.XLEN(XLEN), .PLEN(PLEN), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .ready_o(ready_o),
    .adr_i(adr_i), .size_i(size_i), .we_i(we_i), .lock_i(lock_i), .d_i(d_i),
    .exception_i(exception_i), .misaligned_i(misaligned_i),
    .is_cache_access_i(is_cache_access_i), .is_ext_access_i(is_ext_access_i),
    .is_tcm_access_i(is_tcm_access_i), .flush_i(flush_i),
    .cache_req_o(cache_req_o), .cache_ack_i(cache_ack_i), .cache_err_i(cache_err_i), .cache_q_i(cache_q_i),
    .ext_req_o(ext_req_o), .ext_ack_i(ext_ack_i), .ext_err_i(ext_err_i), .ext_q_i(ext_q_i),
    .tcm_req_o(tcm_req_o), .tcm_ack_i(tcm_ack_i), .tcm_err_i(tcm_err_i), .tcm_q_i(tcm_q_i),
    .tgt_adr_o(tgt_adr_o), .tgt_size_o(tgt_size_o), .tgt_we_o(tgt_we_o),
    .tgt_lock_o(tgt_lock_o), .tgt_d_o(tgt_d_o),
    .ack_o(ack_o), .q_o(q_o), .err_o(err_o), .misaligned_o(misaligned_o)
  );

  typedef struct packed {
    logic [XLEN-1:0] q;
    logic            err;
    logic            mis;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every response strobe is matched against the oldest expectation
  always @(negedge clk_i) begin : mon
    rsp_t e;
    if (!rst_i && ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got ack_o=1 expected no response at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_q", q_o, e.q);
        chk("rsp_err", {63'd0, err_o}, {63'd0, e.err});
        chk("rsp_mis", {63'd0, misaligned_o}, {63'd0, e.mis});
      end
    end
  end

  task automatic push(input logic [63:0] q, input logic err, input logic mis);
    rsp_t e;
    e.q = q; e.err = err; e.mis = mis;
    exp_q.push_back(e);
  endtask

  // Present one request at a negedge once ready; returns 1ns after acceptance edge
  task automatic issue(input logic [63:0] adr, input logic [2:0] size, input logic we,
                       input logic [63:0] d, input logic exc, input logic mis,
                       input logic c, input logic e, input logic t);
    int k;
    k = 0;
    @(negedge clk_i);
    while (ready_o !== 1'b1 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (ready_o !== 1'b1) begin
      n_total++;
      $display("FAIL ready_wait: got ready_o=%b expected 1 within 20 cycles", ready_o);
    end
    adr_i = adr; size_i = size; we_i = we; d_i = d; lock_i = 1'b0;
    exception_i = exc; misaligned_i = mis;
    is_cache_access_i = c; is_ext_access_i = e; is_tcm_access_i = t;
    req_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_i = 1'b0; exception_i = 1'b0; misaligned_i = 1'b0;
    is_cache_access_i = 1'b0; is_ext_access_i = 1'b0; is_tcm_access_i = 1'b0;
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    rst_i = 1'b1; req_i = 1'b0; adr_i = '0; size_i = '0; we_i = 1'b0; lock_i = 1'b0; d_i = '0;
    exception_i = 1'b0; misaligned_i = 1'b0; flush_i = 1'b0;
    is_cache_access_i = 1'b0; is_ext_access_i = 1'b0; is_tcm_access_i = 1'b0;
    cache_ack_i = 1'b0; cache_err_i = 1'b0; cache_q_i = '0;
    ext_ack_i = 1'b0; ext_err_i = 1'b0; ext_q_i = '0;
    tcm_ack_i = 1'b0; tcm_err_i = 1'b0; tcm_q_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_ack", {63'd0, ack_o}, 64'd0);
    chk("rst_reqs", {61'd0, cache_req_o, ext_req_o, tcm_req_o}, 64'd0);
    chk("rst_q", q_o, 64'd0);
    chk("rst_tgt_adr", tgt_adr_o, 64'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // TCM read WORD, ack in the first request cycle
    issue(64'h1000, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(64'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("tcm_req", {61'd0, cache_req_o, ext_req_o, tcm_req_o}, 64'd1);
    chk("tcm_busy_ready", {63'd0, ready_o}, 64'd0);
    chk("tgt_adr", tgt_adr_o, 64'h1000);
    chk("tgt_size", {61'd0, tgt_size_o}, 64'd2);
    tcm_ack_i = 1'b1; tcm_q_i = 64'hDEADBEEF;
    @(posedge clk_i); #1 tcm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("tcm_ack_cycle", {62'd0, ack_o, ready_o}, 64'd3);
    chk("tcm_req_drop", {63'd0, tcm_req_o}, 64'd0);

    // Exception wins over routing flags; fault path ack at N+1
    issue(64'h2000, 3'd2, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(64'h0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("exc_ack", {63'd0, ack_o}, 64'd1);
    chk("exc_no_req", {61'd0, cache_req_o, ext_req_o, tcm_req_o}, 64'd0);
    chk("exc_ready_n1", {63'd0, ready_o}, 64'd0);
    @(negedge clk_i);
    chk("exc_ready_n2", {62'd0, ready_o, ack_o}, 64'd2);

    // Misaligned fault and unrouted address
    issue(64'h3001, 3'd2, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(64'h0, 1'b0, 1'b1);
    issue(64'h4000, 3'd3, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(64'h0, 1'b1, 1'b0);

    // EXT write, no ack: watchdog expires after 4 request cycles
    issue(64'h8000_0000, 3'd3, 1'b1, 64'h1122, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(64'h0, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (ext_req_o) cnt++;
      if (ack_o) break;
    end
    chk("wd_req_cycles", 64'(cnt), 64'd4);

    // EXT read with bus error after two wait cycles
    issue(64'h8000_0010, 3'd3, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    ext_ack_i = 1'b1; ext_err_i = 1'b1; ext_q_i = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk_i); #1 ext_ack_i = 1'b0; ext_err_i = 1'b0;

    // Cache write returns zero data
    issue(64'h5000, 3'd2, 1'b1, 64'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(64'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("tgt_we", {63'd0, tgt_we_o}, 64'd1);
    cache_ack_i = 1'b1; cache_q_i = 64'h55;
    @(posedge clk_i); #1 cache_ack_i = 1'b0;

    // Cache read flushed mid-wait; a stray TCM ack is ignored
    issue(64'h6000, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    @(negedge clk_i);
    tcm_ack_i = 1'b1; tcm_q_i = 64'h99;
    @(posedge clk_i); #1 tcm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("flush_still_pending", {62'd0, cache_req_o, ready_o}, 64'd2);
    cache_ack_i = 1'b1; cache_q_i = 64'hBAD;
    @(posedge clk_i); #1 cache_ack_i = 1'b0;
    @(negedge clk_i);
    chk("flush_no_ack", {62'd0, ack_o, ready_o}, 64'd1);

    // Back-to-back: next request presented in the ack_o cycle
    issue(64'h7000, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(64'hA5A5, 1'b0, 1'b0);
    @(negedge clk_i);
    tcm_ack_i = 1'b1; tcm_q_i = 64'hA5A5;
    @(posedge clk_i); #1 tcm_ack_i = 1'b0;
    issue(64'h7100, 3'd2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(64'h77, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("b2b_route", {61'd0, cache_req_o, ext_req_o, tcm_req_o}, 64'd4);
    chk("b2b_adr", tgt_adr_o, 64'h7100);
    cache_ack_i = 1'b1; cache_q_i = 64'h77;
    @(posedge clk_i); #1 cache_ack_i = 1'b0;
    @(negedge clk_i);

    // Async reset during a pending EXT access
    issue(64'h8000_0020, 3'd3, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("pre_rst_ext_req", {63'd0, ext_req_o}, 64'd1);
    #2 rst_i = 1'b1;
    #1 chk("async_rst_ext_req", {63'd0, ext_req_o}, 64'd0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
    chk("post_rst_outs", {60'd0, ack_o, err_o, misaligned_o, ext_req_o}, 64'd0);
    chk("post_rst_tgt", tgt_adr_o, 64'd0);

    repeat (3) @(negedge clk_i);
    chk("all_responses_seen", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
